// File: rtl/cpu_run_checker_pkg.sv
// Shared types for the CPU run checker: FSM state encoding and the
// layout of one expected-value table entry {vld, reg, value}.
package cpu_run_checker_pkg;

   // Sequencer states, exposed on the debug port of the top.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HOLD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Table-entry field widths: the valid flag is one bit, the register
   // index and expected value take the widths of the core they check.
   localparam int TBL_VLD_W = 1;

   // Packed entry width for a given register-index and data width.
   function automatic int tbl_entry_w(input int reg_w, input int data_w);
      return TBL_VLD_W + reg_w + data_w;
   endfunction

endpackage

// File: rtl/cpu_run_checker_if.sv
// Core-facing bus of the CPU run checker: reset/halt control, the PC tap
// and the debug register-file read port.
//
// Read-port protocol: the checker (master) drives rf_rd_addr in cycle k;
// the core (slave) returns regs[rf_rd_addr] on rf_rd_data in cycle k+1.
// There is no back-pressure; every cycle is a new read.
interface cpu_run_checker_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int PC_W   = 8
);
   logic              cpu_n_rst;
   logic              cpu_halt;
   logic [REG_W-1:0]  rf_rd_addr;
   logic [DATA_W-1:0] rf_rd_data;
   logic [PC_W-1:0]   pc;

   modport master (
      output cpu_n_rst,
      output cpu_halt,
      output rf_rd_addr,
      input  rf_rd_data,
      input  pc
   );

   modport slave (
      input  cpu_n_rst,
      input  cpu_halt,
      input  rf_rd_addr,
      output rf_rd_data,
      output pc
   );
endinterface

// File: rtl/cpu_run_checker_tbl.sv
// Expected-value table: NUM_CHK entries of {vld, reg, value}, one
// synchronous write port, one combinational read port indexed by the scan.
module cpu_run_checker_tbl
   import cpu_run_checker_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int REG_W   = 5,
   parameter int NUM_CHK = 4,
   parameter int CHK_W   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [CHK_W-1:0]  wr_sel,
   input  logic              wr_vld,
   input  logic [REG_W-1:0]  wr_reg,
   input  logic [DATA_W-1:0] wr_val,
   input  logic [CHK_W-1:0]  rd_sel,
   output logic              rd_vld,
   output logic [REG_W-1:0]  rd_reg,
   output logic [DATA_W-1:0] rd_val
);
   localparam int ENT_W = tbl_entry_w(REG_W, DATA_W);

   logic [ENT_W-1:0] mem_q [NUM_CHK];

   // Reset clears every entry to {invalid, reg 0, value 0}; writes land next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CHK; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[wr_sel] <= {wr_vld, wr_reg, wr_val};
      end
   end

   assign {rd_vld, rd_reg, rd_val} = mem_q[rd_sel];

endmodule

// File: rtl/cpu_run_checker.sv
// CPU run checker: holds a core in reset, runs it for a cycle budget,
// freezes it, then scans the register file against an expected table.
// Optional feature macro: CPU_RUN_CHECKER_PC_STOP_EN (early stop on a PC match).
module cpu_run_checker
   import cpu_run_checker_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int REG_W   = 5,
   parameter int PC_W    = 8,
   parameter int CNT_W   = 16,
   parameter int NUM_CHK = 4,
   parameter int CHK_W   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  rst_cycles,
   input  logic [CNT_W-1:0]  run_cycles,
   input  logic              tbl_wr_en,
   input  logic [CHK_W-1:0]  tbl_wr_sel,
   input  logic              tbl_wr_vld,
   input  logic [REG_W-1:0]  tbl_wr_reg,
   input  logic [DATA_W-1:0] tbl_wr_val,
`ifdef CPU_RUN_CHECKER_PC_STOP_EN
   input  logic [PC_W-1:0]   stop_pc,
   input  logic              stop_pc_en,
   output logic              stopped_early,
`endif
   cpu_run_checker_if.master core,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CHK_W-1:0]  fail_idx,
   output logic [DATA_W-1:0] fail_data,
   output logic [PC_W-1:0]   halt_pc,
   output state_t            dbg_state
);
   // Scan index needs one extra bit to count past the last entry.
   localparam int SCAN_W = CHK_W + 1;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SCAN_W-1:0] scan_q;
   logic              pipe_vld_q;
   logic              pipe_ent_vld_q;
   logic [CHK_W-1:0]  pipe_idx_q;
   logic [DATA_W-1:0] pipe_val_q;
   logic              pass_q;
   logic [CHK_W-1:0]  fail_idx_q;
   logic [DATA_W-1:0] fail_data_q;
   logic [PC_W-1:0]   halt_pc_q;

   logic              in_check;
   logic              issue;
   logic              mismatch;
   logic              stop_hit;
   logic              start_ok;
   logic              tbl_we;
   logic [CHK_W-1:0]  rd_sel;
   logic              rd_vld;
   logic [REG_W-1:0]  rd_reg;
   logic [DATA_W-1:0] rd_val;

   assign in_check = (state_q == ST_CHECK);
   assign issue    = in_check && (scan_q < SCAN_W'(NUM_CHK));
   // Compare the entry issued last cycle against the data the core returns now.
   assign mismatch = in_check && pipe_vld_q && pipe_ent_vld_q &&
                     (core.rf_rd_data != pipe_val_q);
   assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign tbl_we   = tbl_wr_en && !busy;
   assign rd_sel   = scan_q[CHK_W-1:0];

`ifdef CPU_RUN_CHECKER_PC_STOP_EN
   assign stop_hit = (state_q == ST_RUN) && stop_pc_en && (core.pc == stop_pc);
`else
   assign stop_hit = 1'b0;
`endif

   cpu_run_checker_tbl #(
      .DATA_W  (DATA_W),
      .REG_W   (REG_W),
      .NUM_CHK (NUM_CHK),
      .CHK_W   (CHK_W)
   ) u_tbl (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (tbl_we),
      .wr_sel (tbl_wr_sel),
      .wr_vld (tbl_wr_vld),
      .wr_reg (tbl_wr_reg),
      .wr_val (tbl_wr_val),
      .rd_sel (rd_sel),
      .rd_vld (rd_vld),
      .rd_reg (rd_reg),
      .rd_val (rd_val)
   );

   // State and cycle-counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, counter update and state-decoded core controls.
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      core.cpu_n_rst  = 1'b0;
      core.cpu_halt   = 1'b1;
      core.rf_rd_addr = '0;
      busy            = 1'b0;
      done            = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (state_q == ST_DONE) begin
               core.cpu_n_rst = 1'b1;
               done           = 1'b1;
            end
            if (start) begin
               state_d = ST_HOLD;
               cnt_d   = (rst_cycles == '0) ? CNT_W'(1) : rst_cycles;
            end
         end
         ST_HOLD: begin
            core.cpu_halt = 1'b0;
            busy          = 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
               state_d = ST_RUN;
               cnt_d   = run_cycles;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RUN: begin
            // A zero budget or a PC stop freezes the core in this very cycle.
            core.cpu_n_rst = 1'b1;
            core.cpu_halt  = (cnt_q == '0) || stop_hit;
            busy           = 1'b1;
            if ((cnt_q <= CNT_W'(1)) || stop_hit) begin
               state_d = ST_CHECK;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_CHECK: begin
            core.cpu_n_rst = 1'b1;
            busy           = 1'b1;
            // Invalid entries and entries after a failure never reach the core.
            if (issue && rd_vld && !mismatch) begin
               core.rf_rd_addr = rd_reg;
            end
            if (mismatch || !issue) begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Two-stage scan: issue entry k now, hold its expectation for the compare next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_q         <= '0;
         pipe_vld_q     <= 1'b0;
         pipe_ent_vld_q <= 1'b0;
         pipe_idx_q     <= '0;
         pipe_val_q     <= '0;
      end else if (issue) begin
         scan_q         <= scan_q + SCAN_W'(1);
         pipe_vld_q     <= 1'b1;
         pipe_ent_vld_q <= rd_vld;
         pipe_idx_q     <= rd_sel;
         pipe_val_q     <= rd_val;
      end else begin
         scan_q     <= '0;
         pipe_vld_q <= 1'b0;
      end
   end

   // Result registers: cleared by start, set by the first mismatch or a clean scan.
   always_ff @(posedge clk) begin
      if (rst) begin
         pass_q      <= 1'b0;
         fail_idx_q  <= '0;
         fail_data_q <= '0;
      end else if (start_ok) begin
         pass_q      <= 1'b0;
         fail_idx_q  <= '0;
         fail_data_q <= '0;
      end else if (mismatch) begin
         pass_q      <= 1'b0;
         fail_idx_q  <= pipe_idx_q;
         fail_data_q <= core.rf_rd_data;
      end else if (in_check && !issue) begin
         pass_q <= 1'b1;
      end
   end

   // Frozen PC is captured in the first CHECK cycle; the core is halted by then.
   always_ff @(posedge clk) begin
      if (rst) begin
         halt_pc_q <= '0;
      end else if (in_check && (scan_q == '0)) begin
         halt_pc_q <= core.pc;
      end
   end

`ifdef CPU_RUN_CHECKER_PC_STOP_EN
   logic stopped_q;

   // Remembers that RUN ended on the PC match rather than the count.
   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         stopped_q <= 1'b0;
      end else if (stop_hit) begin
         stopped_q <= 1'b1;
      end
   end

   assign stopped_early = stopped_q;
`endif

   assign pass      = pass_q;
   assign fail_idx  = fail_idx_q;
   assign fail_data = fail_data_q;
   assign halt_pc   = halt_pc_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_cpu_run_checker.sv
// Bench for cpu_run_checker: a tiny fake core, directed and randomized runs,
// expected results from a program-level model of the core and the table rules.
module tb_cpu_run_checker;
   import cpu_run_checker_pkg::*;

   localparam int DATA_W  = 32;
   localparam int REG_W   = 5;
   localparam int PC_W    = 8;
   localparam int CNT_W   = 16;
   localparam int NUM_CHK = 4;
   localparam int CHK_W   = 2;

   // ---------------- clock / reset / DUT ----------------
   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [CNT_W-1:0]  rst_cycles;
   logic [CNT_W-1:0]  run_cycles;
   logic              tbl_wr_en;
   logic [CHK_W-1:0]  tbl_wr_sel;
   logic              tbl_wr_vld;
   logic [REG_W-1:0]  tbl_wr_reg;
   logic [DATA_W-1:0] tbl_wr_val;
   logic              busy;
   logic              done;
   logic              pass;
   logic [CHK_W-1:0]  fail_idx;
   logic [DATA_W-1:0] fail_data;
   logic [PC_W-1:0]   halt_pc;
   state_t            dbg_state;
`ifdef CPU_RUN_CHECKER_PC_STOP_EN
   logic [PC_W-1:0]   stop_pc;
   logic              stop_pc_en;
   logic              stopped_early;
`endif

   always #5 clk = ~clk;

   cpu_run_checker_if #(.DATA_W(DATA_W), .REG_W(REG_W), .PC_W(PC_W)) core_if ();

   cpu_run_checker #(
      .DATA_W(DATA_W), .REG_W(REG_W), .PC_W(PC_W),
      .CNT_W(CNT_W), .NUM_CHK(NUM_CHK), .CHK_W(CHK_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .rst_cycles    (rst_cycles),
      .run_cycles    (run_cycles),
      .tbl_wr_en     (tbl_wr_en),
      .tbl_wr_sel    (tbl_wr_sel),
      .tbl_wr_vld    (tbl_wr_vld),
      .tbl_wr_reg    (tbl_wr_reg),
      .tbl_wr_val    (tbl_wr_val),
`ifdef CPU_RUN_CHECKER_PC_STOP_EN
      .stop_pc       (stop_pc),
      .stop_pc_en    (stop_pc_en),
      .stopped_early (stopped_early),
`endif
      .core          (core_if),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .fail_idx      (fail_idx),
      .fail_data     (fail_data),
      .halt_pc       (halt_pc),
      .dbg_state     (dbg_state)
   );

   // ---------------- fake core ----------------
   // Program: step at pc 10 writes x1=DEADBEEF, pc 12 writes x3=7,
   // every other pc p writes x(4+p%4) = 3p+1. Reset zeroes pc and registers.
   logic [DATA_W-1:0] core_rf [32];
   logic [PC_W-1:0]   core_pc;
   int                core_steps;

   assign core_if.pc = core_pc;

   always @(posedge clk) begin
      core_if.rf_rd_data <= core_rf[core_if.rf_rd_addr];
      if (!core_if.cpu_n_rst) begin
         core_pc    <= '0;
         core_steps <= 0;
         for (int i = 0; i < 32; i++) core_rf[i] <= '0;
      end else if (!core_if.cpu_halt) begin
         core_pc    <= core_pc + 8'd1;
         core_steps <= core_steps + 1;
         if (core_pc == 8'd10) core_rf[1] <= 32'hDEADBEEF;
         else if (core_pc == 8'd12) core_rf[3] <= 32'h7;
         else core_rf[4 + int'(core_pc[1:0])] <= 32'(core_pc) * 32'd3 + 32'd1;
      end
   end

   // ---------------- reference model ----------------
   logic              m_vld [NUM_CHK];
   logic [REG_W-1:0]  m_reg [NUM_CHK];
   logic [DATA_W-1:0] m_val [NUM_CHK];

   // Value of register r after the core has executed n steps from reset.
   function automatic logic [DATA_W-1:0] model_reg(input int r, input int n);
      logic [DATA_W-1:0] v = '0;
      for (int p = 0; p < n; p++) begin
         int pp = p % 256;
         if (pp == 10) begin
            if (r == 1) v = 32'hDEADBEEF;
         end else if (pp == 12) begin
            if (r == 3) v = 32'h7;
         end else if (r == 4 + (pp % 4)) begin
            v = 32'(pp * 3 + 1);
         end
      end
      return v;
   endfunction

   // ---------------- scoreboard ----------------
   logic [34:0] exp_q [$];
   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tbl_write(input int sel, input logic vld, input int r, input logic [DATA_W-1:0] val);
      tbl_wr_en  = 1'b1;
      tbl_wr_sel = CHK_W'(sel);
      tbl_wr_vld = vld;
      tbl_wr_reg = REG_W'(r);
      tbl_wr_val = val;
      tick();
      tbl_wr_en = 1'b0;
      m_vld[sel] = vld;
      m_reg[sel] = REG_W'(r);
      m_val[sel] = val;
   endtask

   task automatic clear_model();
      for (int i = 0; i < NUM_CHK; i++) begin
         m_vld[i] = 1'b0;
         m_reg[i] = '0;
         m_val[i] = '0;
      end
   endtask

   // Launches one run and checks timing, result and frozen core state.
   // steps_exp: enabled core edges expected; forbid: register index that must never be read.
   task automatic run_case(input string tag, input int rcyc, input int ncyc,
                           input int steps_exp, input bit disturb, input int forbid);
      int          fail_k;
      logic [34:0] exp_res;
      logic [34:0] got_res;
      int          hold_exp, run_len, chk_len;
      int          cyc, hold, forbidden;
      bit          sp, wp;
      fail_k  = -1;
      exp_res = {1'b1, 2'd0, 32'd0};
      for (int k = 0; k < NUM_CHK; k++) begin
         logic [DATA_W-1:0] act;
         act = model_reg(int'(m_reg[k]), steps_exp);
         if (fail_k < 0 && m_vld[k] && act != m_val[k]) begin
            fail_k  = k;
            exp_res = {1'b0, CHK_W'(k), act};
         end
      end
      exp_q.push_back(exp_res);
      hold_exp = (rcyc == 0) ? 1 : rcyc;
      run_len  = (ncyc == 0) ? 1 : ((steps_exp < ncyc) ? steps_exp + 1 : ncyc);
      chk_len  = (fail_k >= 0) ? fail_k + 2 : NUM_CHK + 1;

      rst_cycles = CNT_W'(rcyc);
      run_cycles = CNT_W'(ncyc);
      start      = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_busy_rise"}, 64'(busy), 64'(1));

      cyc = 0; hold = 0; forbidden = 0; sp = 0; wp = 0;
      while (busy && cyc < 3000) begin
         start     = 1'b0;
         tbl_wr_en = 1'b0;
         cyc++;
         if (!core_if.cpu_n_rst) hold++;
         if (forbid >= 0 && int'(core_if.rf_rd_addr) == forbid) forbidden++;
         if (disturb && !sp && core_if.cpu_n_rst && !core_if.cpu_halt) begin
            start = 1'b1;
            sp    = 1'b1;
         end else if (disturb && !wp && core_if.cpu_n_rst && core_if.cpu_halt) begin
            tbl_wr_en  = 1'b1;
            tbl_wr_sel = '0;
            tbl_wr_vld = 1'b1;
            tbl_wr_reg = REG_W'(2);
            tbl_wr_val = 32'h1234;
            wp         = 1'b1;
         end
         tick();
      end
      start     = 1'b0;
      tbl_wr_en = 1'b0;

      got_res = {pass, fail_idx, fail_data};
      check({tag, "_done"},       64'(done), 64'(1));
      check({tag, "_busy_len"},   64'(cyc), 64'(hold_exp + run_len + chk_len));
      check({tag, "_hold_len"},   64'(hold), 64'(hold_exp));
      check({tag, "_result"},     64'(got_res), 64'(exp_q.pop_front()));
      check({tag, "_halt_pc"},    64'(halt_pc), 64'(steps_exp % 256));
      check({tag, "_core_steps"}, 64'(core_steps), 64'(steps_exp));
      check({tag, "_halt_done"},  64'(core_if.cpu_halt), 64'(1));
      if (forbid >= 0) check({tag, "_forbidden_read"}, 64'(forbidden), 64'(0));
      if (disturb) check({tag, "_disturb_hit"}, 64'({sp, wp}), 64'(3));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int ok;
      rst = 1'b1; start = 1'b0; rst_cycles = '0; run_cycles = '0;
      tbl_wr_en = 1'b0; tbl_wr_sel = '0; tbl_wr_vld = 1'b0; tbl_wr_reg = '0; tbl_wr_val = '0;
`ifdef CPU_RUN_CHECKER_PC_STOP_EN
      stop_pc = '0; stop_pc_en = 1'b0;
`endif
      clear_model();
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("rst_n_rst",     64'(core_if.cpu_n_rst), 64'(0));
      check("rst_halt",      64'(core_if.cpu_halt), 64'(1));
      check("rst_busy",      64'(busy), 64'(0));
      check("rst_done",      64'(done), 64'(0));
      check("rst_pass",      64'(pass), 64'(0));
      check("rst_fail_idx",  64'(fail_idx), 64'(0));
      check("rst_fail_data", 64'(fail_data), 64'(0));
      check("rst_halt_pc",   64'(halt_pc), 64'(0));
      check("rst_rd_addr",   64'(core_if.rf_rd_addr), 64'(0));
      check("rst_state",     64'(dbg_state), 64'(ST_IDLE));

      // Basic pass: x1 loaded by the program
      tbl_write(0, 1'b1, 1, 32'hDEADBEEF);
      run_case("pass", 2, 44, 44, 1'b0, -1);
      repeat (3) tick();
      check("hold_done", 64'(done), 64'(1));
      check("hold_pass", 64'(pass), 64'(1));

      // First mismatch at entry 2; entry 3 (reg 9) must never be read
      tbl_write(2, 1'b1, 3, 32'h5);
      tbl_write(3, 1'b1, 9, 32'h0);
      run_case("mism", 2, 44, 44, 1'b0, 9);

      // Zero run budget: core never steps, x1 stays at its reset value
      tbl_write(0, 1'b1, 1, 32'h0);
      tbl_write(2, 1'b0, 0, 32'h0);
      tbl_write(3, 1'b0, 0, 32'h0);
      run_case("zero_run", 1, 0, 0, 1'b0, -1);

      // start in RUN and table write in CHECK are ignored; table survives
      tbl_write(0, 1'b1, 1, 32'hDEADBEEF);
      run_case("ignore", 3, 44, 44, 1'b1, -1);
      run_case("ignore_after", 0, 44, 44, 1'b0, -1);

      // Reset in the middle of RUN
      rst_cycles = CNT_W'(2);
      run_cycles = CNT_W'(44);
      start = 1'b1;
      tick();
      start = 1'b0;
      ok = 0;
      for (int i = 0; i < 100 && ok == 0; i++) begin
         if (busy && core_if.cpu_n_rst) ok = 1;
         else tick();
      end
      check("midrst_in_run", 64'(ok), 64'(1));
      repeat (5) tick();
      rst = 1'b1;
      tick();
      check("midrst_n_rst", 64'(core_if.cpu_n_rst), 64'(0));
      check("midrst_busy",  64'(busy), 64'(0));
      check("midrst_done",  64'(done), 64'(0));
      rst = 1'b0;
      clear_model();
      tick();
      run_case("after_rst", 2, 5, 5, 1'b0, -1);

      // Randomized runs
      for (int it = 0; it < 8; it++) begin
         int rc, nc;
         rc = $urandom_range(0, 4);
         nc = $urandom_range(0, 60);
         for (int w = 0; w < 3; w++) begin
            int r;
            logic [DATA_W-1:0] v;
            r = $urandom_range(0, 9);
            v = ($urandom_range(0, 1) == 1) ? model_reg(r, nc) : DATA_W'($urandom);
            tbl_write($urandom_range(0, NUM_CHK - 1), 1'($urandom_range(0, 1)), r, v);
         end
         run_case($sformatf("rand%0d", it), rc, nc, nc, 1'b0, -1);
      end

`ifdef CPU_RUN_CHECKER_PC_STOP_EN
      // Early stop on pc == 0x10
      stop_pc    = 8'h10;
      stop_pc_en = 1'b1;
      run_case("stop", 2, 1000, 16, 1'b0, -1);
      check("stop_flag", 64'(stopped_early), 64'(1));
      stop_pc_en = 1'b0;
      run_case("nostop", 1, 20, 20, 1'b0, -1);
      check("nostop_flag", 64'(stopped_early), 64'(0));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
